imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a program as a byte stream and writes it,

---
 rtl/imem_loader_pkg.sv | 42 ++++
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader_byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared constants, state encoding and helper functions for the instruction
// memory loader.
//   state_t        : loader FSM states (CHK always present in the encoding)
//   ST_*           : 3-bit constants derived from state_t, used for the state
//                    register so that legacy tools see plain vectors
//   BYTES_PER_WORD : bytes assembled into one 32-bit imem word
//   LEN_BYTES      : bytes in the little-endian word-count header
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_LEN_LO = 3'(LEN_LO);
  localparam logic [2:0] ST_LEN_HI = 3'(LEN_HI);
  localparam logic [2:0] ST_DATA   = 3'(DATA);
  localparam logic [2:0] ST_CHK    = 3'(CHK);
  localparam logic [2:0] ST_DONE   = 3'(DONE);

  // True for every state in which a load is in progress and bytes are taken.
  function automatic logic st_loading(input logic [2:0] s);
    logic r;
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte-stream input channel plus imem write port of the loader.
//   in_valid/in_data/in_ready : host byte stream (transfer = in_valid & in_ready)
//   mem_we/mem_addr/mem_wdata : instruction-memory write port
// Modports:
//   slave  : the loader (consumes the stream, drives the write port)
//   master : the host / environment side
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  import imem_loader_pkg::*;

  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          in_ready;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [8*BYTES_PER_WORD-1:0]   mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_packer
// Packs a little-endian byte stream into 32-bit words.
//   clk_i        : rising-edge clock
//   rst_i        : synchronous active-high reset
//   clr_i        : restart packing at byte 0 (new load)
//   byte_valid_i : byte_i is a data byte accepted this cycle
//   byte_i       : data byte
//   word_o       : assembled word, meaningful while word_valid_o is high
//   word_valid_o : pulses in the cycle the 4th byte of a word is accepted
// The first three bytes of a word are held in a 24-bit shift register; the
// fourth byte is combined directly so the parent can register the word on the
// same edge that accepts the byte.
// -----------------------------------------------------------------------------
module imem_loader_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;

  // Byte position counter and shift register; newest byte enters at the top.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else if (byte_valid_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {byte_i, sr_q[23:8]};
    end else begin
      cnt_q <= cnt_q;
      sr_q  <= sr_q;
    end
  end

  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, sr_q};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Receives a program image as a byte
// stream (LEN lo, LEN hi, then 4*LEN little-endian data bytes), writes it word
// by word into imem, and holds the core in reset until a complete, valid image
// has been written.
// Ports:
//   clk_i     : rising-edge clock
//   rst_i     : synchronous active-high reset (aborts any load in progress)
//   start_i   : one-cycle pulse, begins a load (honoured in IDLE/DONE only)
//   bus       : imem_loader_if.slave -- byte stream in, imem write port out
//   cpu_rst_o : core reset, low only in DONE without error
//   busy_o    : load in progress
//   done_o    : image load finished (held until next start or reset)
//   err_o     : image rejected (held until next start or reset)
// Configuration:
//   IMEM_LOADER_CHECKSUM_EN : when defined, one extra byte follows the data and
//   must equal the XOR of all data bytes; otherwise DONE follows the last data
//   byte directly.
// Words past the imem capacity are consumed but not written; the image is then
// rejected when the load completes.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  imem_loader_if.slave    bus,
  output logic            cpu_rst_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);
  import imem_loader_pkg::*;

  localparam int          WA    = ADDR_WIDTH - 2;
  localparam logic [31:0] DEPTH = 32'd1 << WA;

  logic [2:0]            state_q,    state_d;
  logic [15:0]           len_q,      len_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic                  ovf_q,      ovf_d;
  logic [7:0]            csum_q,     csum_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q,   mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  cpu_rst_q,  cpu_rst_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;

  logic                  xfer;
  logic                  start_ok;
  logic                  pk_valid;
  logic [31:0]           pk_word;
  logic                  word_fits;
  logic                  last_word;

  assign xfer      = bus.in_valid && in_ready_q;
  assign start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign word_fits = 32'(word_cnt_q) < DEPTH;
  assign last_word = (word_cnt_q == (len_q - 16'd1));

  imem_loader_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (start_ok),
    .byte_valid_i (xfer && (state_q == ST_DATA)),
    .byte_i       (bus.in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  // Next-state, counters, checksum and next values of all output registers.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    ovf_d       = ovf_q;
    csum_d      = csum_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (start_ok) begin
      state_d    = ST_LEN_LO;
      len_d      = 16'd0;
      word_cnt_d = 16'd0;
      ovf_d      = 1'b0;
      csum_d     = 8'd0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_LEN_LO: begin
          if (xfer) begin
            len_d   = {len_q[15:8], bus.in_data};
            state_d = ST_LEN_HI;
          end else begin
            state_d = ST_LEN_LO;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len_d = {bus.in_data, len_q[7:0]};
            if ({bus.in_data, len_q[7:0]} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_DONE;
              err_d   = 1'b0;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_LEN_HI;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum_d = csum_q ^ bus.in_data;
          end else begin
            csum_d = csum_q;
          end
          if (pk_valid) begin
            word_cnt_d = word_cnt_q + 16'd1;
            // Out-of-range words are swallowed so mem_addr never wraps.
            if (word_fits) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = {word_cnt_q[WA-1:0], 2'b00};
              mem_wdata_d = pk_word;
            end else begin
              ovf_d = 1'b1;
            end
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_DONE;
              err_d   = ovf_d;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_CHK: begin
          if (xfer) begin
            state_d = ST_DONE;
            err_d   = ovf_q || (bus.in_data != csum_q);
          end else begin
            state_d = ST_CHK;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Status outputs follow the state being entered so they are registered
    // together with it.
    in_ready_d = st_loading(state_d);
    busy_d     = st_loading(state_d);
    done_d     = (state_d == ST_DONE);
    cpu_rst_d  = !done_d || err_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= 16'd0;
      word_cnt_q  <= 16'd0;
      ovf_q       <= 1'b0;
      csum_q      <= 8'd0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      ovf_q       <= ovf_d;
      csum_q      <= csum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst_o     = cpu_rst_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Drives the same byte stream into two loaders: a 64-word imem (ADDR_WIDTH=8)
// and a 4-word imem (ADDR_WIDTH=4). Expected writes and flags are derived from
// the image itself: word k goes to byte address 4*k if k < capacity, and the
// image is rejected when it exceeds capacity (or carries a bad checksum when
// IMEM_LOADER_CHECKSUM_EN is defined).
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  logic cpu_rst, busy, done, err;
  logic cpu_rst_s, busy_s, done_s, err_s;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int DEPTH_L = 64;
  localparam int DEPTH_S = 4;

  logic [31:0] img[$];
  logic [39:0] wr_q[$];
  logic [39:0] wr_s_q[$];

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(8)) bus ();
  imem_loader_if #(.ADDR_WIDTH(4)) bus_s ();

  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus_s.in_valid = in_valid;
  assign bus_s.in_data  = in_data;

  imem_loader #(.WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus.slave),
    .cpu_rst_o(cpu_rst), .busy_o(busy), .done_o(done), .err_o(err)
  );

  imem_loader #(.WIDTH(32), .ADDR_WIDTH(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus_s.slave),
    .cpu_rst_o(cpu_rst_s), .busy_o(busy_s), .done_o(done_s), .err_o(err_s)
  );

  // Record every imem write of both loaders as {addr, data}.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1)   wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus_s.mem_we === 1'b1) wr_s_q.push_back({4'h0, bus_s.mem_addr, bus_s.mem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (bus.in_ready !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    n_checks++;
    if (g >= 40) begin
      n_fail++;
      $display("FAIL send_byte_ready: in_ready=%b, required 1 within 40 cycles", bus.in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    n_checks++;
    if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, busy, done, err} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_large: rdy=%b we=%b addr=%h wdata=%h cpu_rst=%b busy=%b done=%b err=%b, required 0 0 00 00000000 1 0 0 0",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, busy, done, err);
    end
    n_checks++;
    if ({bus_s.in_ready, bus_s.mem_we, bus_s.mem_addr, bus_s.mem_wdata, cpu_rst_s, busy_s, done_s, err_s} !==
        {1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_small: rdy=%b we=%b addr=%h wdata=%h cpu_rst=%b busy=%b done=%b err=%b, required 0 0 0 00000000 1 0 0 0",
               bus_s.in_ready, bus_s.mem_we, bus_s.mem_addr, bus_s.mem_wdata, cpu_rst_s, busy_s, done_s, err_s);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_data();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, busy, done, err} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_data_outputs: rdy=%b we=%b addr=%h wdata=%h cpu_rst=%b busy=%b done=%b err=%b, required reset values",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, busy, done, err);
    end
    wr_q.delete();
    wr_s_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'($urandom_range(0, 255));
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_data_idle: in_ready=%b busy=%b, required 0 0", bus.in_ready, busy);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_q.size() != 0 || wr_s_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_data_no_write: writes=%0d/%0d, required 0/0", wr_q.size(), wr_s_q.size());
    end
  endtask

  // Load img; gap 0 = back-to-back bytes, 1 = one idle cycle after each byte,
  // 2 = random 0..2 idle cycles. mid_start pulses start during DATA.
  task automatic run_load(input string name, input int gap, input bit bad_chk, input bit mid_start);
    logic [7:0] bytes[$];
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    logic [39:0] e;
    bit   exp_err_l, exp_err_s, chk_err;
    int   n = img.size();
    int   g = 0;
    int   n_l, n_s;
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    foreach (img[k]) begin
      for (int j = 0; j < 4; j++) begin
        b = img[k][8*j +: 8];
        bytes.push_back(b);
        x = x ^ b;
      end
    end
    chk_err = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    bytes.push_back(bad_chk ? (x ^ 8'h01) : x);
    chk_err = bad_chk;
`endif
    wr_q.delete();
    wr_s_q.delete();
    pulse_start();
    foreach (bytes[i]) begin
      if (mid_start && i == 4) start = 1'b1;
      send_byte(bytes[i]);
      start = 1'b0;
      if (gap == 1) tick();
      else if (gap == 2) repeat ($urandom_range(0, 2)) tick();
    end
    while (done !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    tick();

    exp_err_l = (n > DEPTH_L) || chk_err;
    exp_err_s = (n > DEPTH_S) || chk_err;
    n_l = (n < DEPTH_L) ? n : DEPTH_L;
    n_s = (n < DEPTH_S) ? n : DEPTH_S;

    n_checks++;
    if ({done, busy, err, cpu_rst, bus.in_ready} !== {1'b1, 1'b0, exp_err_l, exp_err_l, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_flags_large: done/busy/err/cpu_rst/rdy=%b%b%b%b%b, required 10%b%b0",
               name, done, busy, err, cpu_rst, bus.in_ready, exp_err_l, exp_err_l);
    end
    n_checks++;
    if ({done_s, busy_s, err_s, cpu_rst_s, bus_s.in_ready} !== {1'b1, 1'b0, exp_err_s, exp_err_s, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_flags_small: done/busy/err/cpu_rst/rdy=%b%b%b%b%b, required 10%b%b0",
               name, done_s, busy_s, err_s, cpu_rst_s, bus_s.in_ready, exp_err_s, exp_err_s);
    end
    n_checks++;
    if (wr_q.size() != n_l || wr_s_q.size() != n_s) begin
      n_fail++;
      $display("FAIL %s_write_count: large=%0d small=%0d, required %0d %0d",
               name, wr_q.size(), wr_s_q.size(), n_l, n_s);
    end
    for (int k = 0; k < n_l && k < wr_q.size(); k++) begin
      e = {8'(4*k), img[k]};
      n_checks++;
      if (wr_q[k] !== e) begin
        n_fail++;
        $display("FAIL %s_write_large[%0d]: got %h, required %h", name, k, wr_q[k], e);
      end
    end
    for (int k = 0; k < n_s && k < wr_s_q.size(); k++) begin
      e = {4'h0, 4'(4*k), img[k]};
      n_checks++;
      if (wr_s_q[k] !== e) begin
        n_fail++;
        $display("FAIL %s_write_small[%0d]: got %h, required %h", name, k, wr_s_q[k], e);
      end
    end
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int k = 0; k < n; k++) img.push_back($urandom());
  endtask

  task automatic test_basic();
    img.delete();
    img.push_back(32'h00100013);
    img.push_back(32'h00200093);
    run_load("basic", 0, 1'b0, 1'b0);
  endtask

  task automatic test_empty();
    img.delete();
    run_load("empty", 0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    fill_img(5);
    run_load("overflow5", 0, 1'b0, 1'b0);
    fill_img(66);
    run_load("overflow66", 2, 1'b0, 1'b0);
  endtask

  task automatic test_gap_mid_start();
    fill_img(4);
    run_load("gap_mid_start", 1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      fill_img($urandom_range(0, 8));
      run_load("b2b", (r % 2 == 0) ? 0 : 2, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_checksum();
    img.delete();
    img.push_back(32'h44332211);
    run_load("chk_good", 0, 1'b0, 1'b0);
    run_load("chk_bad", 0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rst_mid_data();
    test_basic();
    test_empty();
    test_overflow();
    test_gap_mid_start();
    test_back_to_back();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
